branch_predictor: RTL

- Fetch-side branch predictor for the MIPS 5-stage pipeline. Conditional branches (beq/bne/bgtz/blez/bltz/bgez/bltzal/bgezal) now resolve in E, which takes the comparator off the D-stage forwarding path.
- Holds a direct-mapped table of 2-bit counters plus tag and target per entry (BHT+BTB). It predicts at F and honours the MIPS delay slot.
- It carries each prediction F→D→E, checks it against the E-stage comparator result, and drives mispredict recovery and table update.
- j/jal/jr/jalr are out of scope.

---
 rtl/branch_predictor.sv | 138 +++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-side BHT+BTB branch predictor for a 5-stage MIPS pipeline.
// Predicts at F, honours the delay slot, resolves in E and trains the table.
module branch_predictor #(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        stallE,
  input  logic        flushE,
  input  logic        branchE,
  input  logic        takenE,
  input  logic [31:0] branch_targetE,
  input  logic [31:0] pcE,
  output logic        pred_redirectF,
  output logic [31:0] pred_targetF,
  output logic        mispredictE,
  output logic [31:0] recover_pcE
);
  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic              valid_q  [N];
  logic [1:0]        ctr_q    [N];
  logic [TAG_W-1:0]  tag_q    [N];
  logic [31:0]       target_q [N];

  logic              pend_valid_q, pend_valid_d;
  logic [31:0]       pend_target_q, pend_target_d;
  logic              pred_taken_d_q, pred_taken_d_d;
  logic [31:0]       pred_target_d_q, pred_target_d_d;
  logic              pred_taken_e_q, pred_taken_e_d;
  logic [31:0]       pred_target_e_q, pred_target_e_d;

  // F-stage lookup sees the table as it was before this cycle's E update
  logic [IDX_W-1:0]  idx_f, idx_e;
  logic [TAG_W-1:0]  tag_f, tag_e;
  logic              hit_f, pred_f, hit_e, upd_en, wr_en;
  logic [31:0]       target_f;
  logic [1:0]        ctr_e, ctr_new;

  assign idx_f    = pcF[IDX_W+1:2];
  assign tag_f    = pcF[31:IDX_W+2];
  assign hit_f    = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign pred_f   = hit_f && ctr_q[idx_f][1];
  assign target_f = target_q[idx_f];

  assign idx_e  = pcE[IDX_W+1:2];
  assign tag_e  = pcE[31:IDX_W+2];
  assign hit_e  = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign ctr_e  = ctr_q[idx_e];
  assign upd_en = branchE && !stallE;
  // a not-taken branch that misses leaves the entry alone
  assign wr_en  = upd_en && (takenE || hit_e);

  always_comb begin
    ctr_new = ctr_e;
    if (takenE) begin
      if (!hit_e)              ctr_new = 2'b10;
      else if (ctr_e != 2'b11) ctr_new = ctr_e + 2'd1;
    end else if (ctr_e != 2'b00) begin
      ctr_new = ctr_e - 2'd1;
    end
  end

  assign mispredictE = !rst && upd_en &&
                       ((pred_taken_e_q != takenE) ||
                        (pred_taken_e_q && takenE && (pred_target_e_q != branch_targetE)));
  assign recover_pcE = mispredictE ? (takenE ? branch_targetE : pcE + 32'd8) : 32'd0;

  assign pred_redirectF = pend_valid_q && !mispredictE;
  assign pred_targetF   = pend_target_q;

  always_comb begin
    pend_valid_d    = pend_valid_q;
    pend_target_d   = pend_target_q;
    pred_taken_d_d  = pred_taken_d_q;
    pred_target_d_d = pred_target_d_q;
    pred_taken_e_d  = pred_taken_e_q;
    pred_target_e_d = pred_target_e_q;
    if (!stallF) pend_target_d = target_f;
    if (flushD || mispredictE) pend_valid_d = 1'b0;
    else if (!stallF)          pend_valid_d = pred_f;
    if (flushD || mispredictE) begin
      pred_taken_d_d  = 1'b0;
      pred_target_d_d = 32'd0;
    end else if (!stallD) begin
      pred_taken_d_d  = pred_f;
      pred_target_d_d = target_f;
    end
    if (flushE) begin
      pred_taken_e_d  = 1'b0;
      pred_target_e_d = 32'd0;
    end else if (!stallE) begin
      pred_taken_e_d  = pred_taken_d_q;
      pred_target_e_d = pred_target_d_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q    <= 1'b0;
      pend_target_q   <= 32'd0;
      pred_taken_d_q  <= 1'b0;
      pred_target_d_q <= 32'd0;
      pred_taken_e_q  <= 1'b0;
      pred_target_e_q <= 32'd0;
    end else begin
      pend_valid_q    <= pend_valid_d;
      pend_target_q   <= pend_target_d;
      pred_taken_d_q  <= pred_taken_d_d;
      pred_target_d_q <= pred_target_d_d;
      pred_taken_e_q  <= pred_taken_e_d;
      pred_target_e_q <= pred_target_e_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i]  <= 1'b0;
        ctr_q[i]    <= 2'b01;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
      end
    end else if (wr_en) begin
      ctr_q[idx_e] <= ctr_new;
      if (takenE) begin
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= branch_targetE;
      end
    end
  end
endmodule
